muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M execute unit beside the EX-stage ALU. Takes operands from ID/EX after forwarding
//  and runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Holds one op at a time; core stalls IF/ID/EX on busy.
//  Writes result, rd tag to EX/MEM on the done pulse.
// PARAMETERS
//  XLEN   32  operand/result width
//  TAG_W  5   destination register index width
// PORTS
//  clk     in   1      rising-edge clock (single clock domain)
//  rst_n   in   1      synchronous active-low reset
//  start   in   1      issue request; accepted only when busy==0
//  funct3  in   3      RV32M funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a    in   XLEN   rs1 value (post-forwarding)
//  op_b    in   XLEN   rs2 value (post-forwarding)
//  rd_in   in   TAG_W  destination register of issued op
//  flush   in   1      kill in-flight op (branch/jump redirect)
//  busy    out  1      op in flight; core must stall issue
//  done    out  1      one-cycle pulse, result/rd_out valid
//  result  out  XLEN   final result, held until next accept
//  rd_out  out  TAG_W  tag of completed op, held with result
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE; busy=0, done=0, result=0, rd_out=0. Aborts op mid-flight.
//  - FSM IDLE -> CALC on start&!busy&!flush; CALC -> DONE after XLEN iterations; DONE -> IDLE next cycle.
//    In DONE: done=1, busy=0. start in DONE is accepted (back-to-back issue), next state CALC.
//  - Accept cycle N: latch funct3, rd_in, |op_a|,|op_b| and result signs. busy=1 from N+1.
//    Iteration i at N+1..N+XLEN; done=1 at N+XLEN+1.
//  - Multiply: shift-add on 2*XLEN product. Operands sign-extend per funct3 (MULHSU: a signed, b unsigned).
//    MUL returns low XLEN bits, MULH* return high XLEN bits.
//  - Divide: restoring radix-2 on magnitudes. Quotient negated if signs differ (signed ops).
//    Remainder takes the dividend's sign.
//  - Special cases skip CALC and go IDLE->DONE, so done=1 at N+1:
//    divisor==0: DIV/DIVU -> all ones; REM/REMU -> op_a.
//    signed overflow (op_a=0x8000_0000, op_b=-1): DIV -> 0x8000_0000, REM -> 0.
//  - start while busy=1: ignored, no state change. start with funct3 outside issue: N/A (all 8 valid).
//  - flush: any state -> IDLE next cycle; busy=0, done suppressed (flush beats done in same cycle).
//    result/rd_out unchanged. start&flush same cycle: start dropped.
//  - result/rd_out update only in the cycle entering DONE; stable otherwise.
//  - No X on outputs after reset; all arithmetic modulo 2^XLEN.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MUL* ops go IDLE->DONE using a one-cycle (2*XLEN) product, done at N+1.
//    Divides unchanged.
//  Undefined: MUL* use the XLEN-cycle shift-add path, done at N+XLEN+1. No hardware multiplier inferred.
// TESTING
//  1 MUL 7*(-3): start funct3=000, a=7, b=0xFFFF_FFFD, rd_in=5 -> done at N+33 (N+1 fast),
//    result=0xFFFF_FFEB, rd_out=5.
//  2 MULH/MULHU/MULHSU a=b=0xFFFF_FFFF -> 0x0000_0000 / 0xFFFF_FFFE / 0xFFFF_FFFF.
//  3 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2, each at N+33.
//  4 Divide by zero: DIV 5/0 -> 0xFFFF_FFFF at N+1; REM 5/0 -> 5.
//    Overflow DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
//  5 Flush at N+10 of DIVU -> busy=0 at N+11, no done pulse, result holds prior value.
//    Next start accepted normally.
//  6 rst_n low at N+5, also start while busy at N+3 -> ignored. After reset: busy=0, done=0, result=0.
//    Back-to-back start in DONE cycle gives second done exactly 33 cycles later.

Source files
------------

// File: rtl/muldiv_if.sv
// Issue/result bundle between the core's EX stage and the RV32M multiply/divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             start;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] rd_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide on operand magnitudes.
// Define MULDIV_FAST_MUL_EN to complete MUL* in one cycle with a full-width product.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       f3;
  logic [TAG_W-1:0] rd_lat;
  logic [XLEN-1:0]  hi, lo, mcand;
  logic             neg_q, neg_r;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] rd_q;

  // Issue-side decode
  logic [2:0]      f3_in;
  logic            sgn_a_in, sgn_b_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    f3_in       = bus.funct3;
    sgn_a_in    = f3_in[2] ? !f3_in[0] : (f3_in[1] ^ f3_in[0]);
    sgn_b_in    = f3_in[2] ? !f3_in[0] : (f3_in[1:0] == 2'b01);
    a_neg_in    = sgn_a_in & bus.op_a[XLEN-1];
    b_neg_in    = sgn_b_in & bus.op_b[XLEN-1];
    abs_a_in    = a_neg_in ? -bus.op_a : bus.op_a;
    abs_b_in    = b_neg_in ? -bus.op_b : bus.op_b;
    div_zero    = f3_in[2] && (bus.op_b == '0);
    div_ovf     = f3_in[2] && !f3_in[0] && (bus.op_a == MIN_INT) && (bus.op_b == '1);
    special_res = '0;
    if (div_zero)
      special_res = f3_in[1] ? bus.op_a : '1;
    else if (!f3_in[1])
      special_res = MIN_INT;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_signed;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, abs_a_in} * {{XLEN{1'b0}}, abs_b_in};
    fast_signed = (a_neg_in ^ b_neg_in) ? -fast_prod : fast_prod;
    fast_res    = (f3_in[1:0] == 2'b00) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
  end
`endif

  // One iteration: hi/lo hold {partial product, multiplier} or {remainder, quotient}.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, calc_res;

  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (f3[2]) begin
      nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], !div_diff[XLEN]};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {nxt_hi, nxt_lo};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -nxt_lo : nxt_lo;
    rem    = neg_r ? -nxt_hi : nxt_hi;
    if (f3[2])
      calc_res = f3[1] ? rem : quo;
    else
      calc_res = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f3       <= '0;
      rd_lat   <= '0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state    <= S_DONE;
            result_q <= calc_res;
            rd_q     <= rd_lat;
          end
        end
        default: begin
          // IDLE and DONE both accept, which gives back-to-back issue from DONE.
          if (bus.start) begin
            f3     <= f3_in;
            rd_lat <= bus.rd_in;
            if (div_zero || div_ovf) begin
              state    <= S_DONE;
              result_q <= special_res;
              rd_q     <= bus.rd_in;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!f3_in[2]) begin
              state    <= S_DONE;
              result_q <= fast_res;
              rd_q     <= bus.rd_in;
            end
`endif
            else begin
              state <= S_CALC;
              cnt   <= '0;
              hi    <= '0;
              lo    <= abs_a_in;
              mcand <= abs_b_in;
              neg_q <= a_neg_in ^ b_neg_in;
              neg_r <= a_neg_in;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state == S_CALC);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Called at a negedge; issues one op and returns at the negedge where done is seen.
  // A nonzero intr_k re-asserts start with a different op at that cycle, which must be ignored.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int intr_k, input string tag);
    int k;
    int lat;
    logic [31:0] exp;
    exp = model(f, a, b);
    lat = latency(f, a, b);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    check({tag, "_busy1"}, 64'(bus.busy), 64'(lat > 1));
    while (!bus.done && k < 100) begin
      if (k == intr_k) begin
        bus.start = 1'b1; bus.funct3 = ~f; bus.op_a = ~a; bus.op_b = b + 1; bus.rd_in = ~rd;
      end
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_res"}, 64'(bus.result), 64'(exp));
    check({tag, "_rd"}, 64'(bus.rd_out), 64'(rd));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    last_res = exp;
    last_rd  = rd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] specials [5];
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    int          ndone;
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h8000_0000;
    specials[3] = 32'h1; specials[4] = 32'h7FFF_FFFF;

    bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd", 64'(bus.rd_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, "mul_7xm3");
    @(negedge clk);
    check("done_pulse_len", 64'(bus.done), 64'd0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, "mulh");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, "mulhu");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, "mulhsu");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, "div_m7_2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "rem_m7_2");
    run_op(3'b101, 32'd100, 32'd7, 5'd7, 0, "divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, 5'd8, 0, "remu_100_7");
    run_op(3'b100, 32'd5, 32'd0, 5'd10, 0, "div_by0");
    run_op(3'b110, 32'd5, 32'd0, 5'd11, 0, "rem_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "rem_ovf");
    @(negedge clk);

    // Flush ten cycles into a DIVU: busy drops, no done, outputs keep the previous op.
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_res_hold", 64'(bus.result), 64'(last_res));
    check("flush_rd_hold", 64'(bus.rd_out), 64'(last_rd));

    // start together with flush is dropped.
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("startflush_busy", 64'(bus.busy), 64'd0);
    check("startflush_done", 64'(bus.done), 64'd0);

    run_op(3'b101, 32'd1000, 32'd3, 5'd21, 0, "after_flush");
    @(negedge clk);
    run_op(3'b100, 32'd12345, 32'hFFFF_FFF0, 5'd22, 3, "ignore_start");
    @(negedge clk);

    // Reset mid-flight.
    bus.start = 1'b1; bus.funct3 = 3'b111; bus.op_a = 32'd99; bus.op_b = 32'd4; bus.rd_in = 5'd23;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_rd", 64'(bus.rd_out), 64'd0);
    repeat (40) @(negedge clk);
    check("midrst_no_done", 64'(bus.done), 64'd0);

    for (int n = 0; n < 40; n++) begin
      rf = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
      run_op(rf, ra, rb, 5'($urandom), 0, $sformatf("rand%0d_f%0d", n, rf));
      if (n % 3 == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
